// File: rtl/muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit (shift-add multiply,
//             restoring divide) with a one-cycle register-file write-back.
//             Optional: MULDIV_EARLY_OUT_EN skips CALC when A==0 or B==0.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic            wb_we,
   output logic [4:0]      wb_addr,
   output logic [XLEN-1:0] wb_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [4:0]            rd_q, rd_d;
   logic [XLEN-1:0]       a_orig_q, a_orig_d;
   logic [XLEN-1:0]       a_mag_q, a_mag_d;
   logic [XLEN-1:0]       b_mag_q, b_mag_d;
   logic                  res_neg_q, res_neg_d;
   logic                  a_neg_q, a_neg_d;
   logic [5:0]            cnt_q, cnt_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  wb_we_q, wb_we_d;
   logic [4:0]            wb_addr_q, wb_addr_d;
   logic [XLEN-1:0]       wb_data_q, wb_data_d;

   logic                  a_signed_in, b_signed_in, a_neg_in, b_neg_in;
   logic [XLEN:0]         mul_sum;
   logic [2*XLEN-1:0]     mul_next;
   logic [XLEN:0]         div_r;
   logic                  div_ge;
   logic [XLEN-1:0]       div_sub, div_rem;
   logic [2*XLEN-1:0]     div_next;
   logic [2*XLEN-1:0]     prod;
   logic [XLEN-1:0]       quo_s, rem_s, fix_result;

   // Unsigned-A ops: MULHU, DIVU, REMU; unsigned-B ops add MULHSU.
   assign a_signed_in = ~(funct3[0] & (funct3[1] | funct3[2]));
   assign b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign a_neg_in    = a_signed_in & rs1_val[XLEN-1];
   assign b_neg_in    = b_signed_in & rs2_val[XLEN-1];

   // Multiplier sits in the low half and is consumed LSB-first while the
   // partial product shifts in from the top.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Remainder in the high half, dividend/quotient in the low half.
   assign div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_ge   = div_r >= {1'b0, b_mag_q};
   assign div_sub  = div_r[XLEN-1:0] - b_mag_q;
   assign div_rem  = div_ge ? div_sub : div_r[XLEN-1:0];
   assign div_next = {div_rem, acc_q[XLEN-2:0], div_ge};

   assign prod  = res_neg_q ? -acc_q : acc_q;
   assign quo_s = res_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_s = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fix_result = '0;
      if (!op_q[2]) begin
         fix_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else if (b_mag_q == '0) begin
         fix_result = op_q[1] ? a_orig_q : '1;
      end else begin
         fix_result = op_q[1] ? rem_s : quo_s;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      a_orig_d  = a_orig_q;
      a_mag_d   = a_mag_q;
      b_mag_d   = b_mag_q;
      res_neg_d = res_neg_q;
      a_neg_d   = a_neg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d      = funct3;
               rd_d      = rd_addr;
               a_orig_d  = rs1_val;
               a_neg_d   = a_neg_in;
               res_neg_d = a_neg_in ^ b_neg_in;
               a_mag_d   = a_neg_in ? -rs1_val : rs1_val;
               b_mag_d   = b_neg_in ? -rs2_val : rs2_val;
               cnt_d     = '0;
               acc_d     = funct3[2] ? {{XLEN{1'b0}}, a_mag_d} : {{XLEN{1'b0}}, b_mag_d};
               state_d   = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
               // A zero operand makes every result a constant or rs1_val.
               if ((rs1_val == '0) || (rs2_val == '0)) begin
                  acc_d   = '0;
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_FIX;
            end
         end
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      wb_we_d   = (state_d == S_DONE) && (rd_q != 5'd0);
      wb_addr_d = (state_d == S_DONE) ? rd_q : wb_addr_q;
      wb_data_d = (state_q == S_FIX) ? fix_result : wb_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         a_orig_q  <= '0;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         res_neg_q <= 1'b0;
         a_neg_q   <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         a_orig_q  <= a_orig_d;
         a_mag_q   <= a_mag_d;
         b_mag_q   <= b_mag_d;
         res_neg_q <= res_neg_d;
         a_neg_q   <= a_neg_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wb_we   = wb_we_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        done;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int checks   = 0;
   int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 34;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   always #5 clk = ~clk;

   // Launches one op from IDLE and waits (bounded) for done; operands are
   // scrambled while busy to confirm they are not re-sampled.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] data,
                         output logic [4:0] addr, output logic we, output int lat,
                         output int busy_low);
      funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rs1_val = ~a; rs2_val = ~b; funct3 = ~f; rd_addr = ~rd;
      lat = 1; busy_low = 0;
      while (!done && lat < 100) begin
         if (!busy) busy_low++;
         @(posedge clk); #1;
         lat++;
      end
      if (!busy) busy_low++;
      data = wb_data; addr = wb_addr; we = wb_we;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_we); end
      checks++; if (wb_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
      checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      logic [31:0] d; logic [4:0] ad; logic we; int lat, bl;
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, d, ad, we, lat, bl);
      checks++; if (d !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_data got=%h exp=ffffffeb", d); end
      checks++; if (ad !== 5'd5) begin failures++; $display("FAIL mul_addr got=%0d exp=5", ad); end
      checks++; if (we !== 1'b1) begin failures++; $display("FAIL mul_we got=%b exp=1", we); end
      checks++; if (lat != 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", lat); end
      checks++; if (bl != 0) begin failures++; $display("FAIL mul_busy low_cycles=%0d exp=0", bl); end
      checks++; if (done !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL mul_pulse done=%b we=%b exp=0,0", done, wb_we); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_after got=%b exp=0", busy); end
      checks++; if (wb_data !== 32'hFFFFFFEB || wb_addr !== 5'd5) begin failures++; $display("FAIL mul_hold data=%h addr=%0d exp=ffffffeb,5", wb_data, wb_addr); end
   endtask

   task automatic test_mul_high();
      logic [2:0]  f[4]   = '{3'b001, 3'b011, 3'b010, 3'b000};
      logic [31:0] a[4]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
      logic [31:0] b[4]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4};
      logic [31:0] exp[4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd12};
      logic [31:0] d; logic [4:0] ad; logic we; int lat, bl;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], 5'(i + 10), d, ad, we, lat, bl);
         checks++; if (d !== exp[i]) begin failures++; $display("FAIL mulh[%0d] got=%h exp=%h", i, d, exp[i]); end
         checks++; if (lat != 34 || ad !== 5'(i + 10)) begin failures++; $display("FAIL mulh_meta[%0d] lat=%0d addr=%0d exp=34,%0d", i, lat, ad, i + 10); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  f[6]   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
      logic [31:0] a[6]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
      logic [31:0] b[6]   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exp[6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1, 32'h80000000, 32'd0};
      logic [31:0] d; logic [4:0] ad; logic we; int lat, bl;
      for (int i = 0; i < 6; i++) begin
         run_op(f[i], a[i], b[i], 5'd3, d, ad, we, lat, bl);
         checks++; if (d !== exp[i]) begin failures++; $display("FAIL div[%0d] got=%h exp=%h", i, d, exp[i]); end
         checks++; if (lat != 34 || we !== 1'b1) begin failures++; $display("FAIL div_meta[%0d] lat=%0d we=%b exp=34,1", i, lat, we); end
      end
   endtask

   task automatic test_div_zero();
      logic [2:0]  f[4]   = '{3'b101, 3'b110, 3'b100, 3'b111};
      logic [31:0] a[4]   = '{32'd5, 32'hFFFFFFFB, 32'd7, 32'd9};
      logic [31:0] exp[4] = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd9};
      logic [31:0] d; logic [4:0] ad; logic we; int lat, bl;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], 32'd0, 5'd17, d, ad, we, lat, bl);
         checks++; if (d !== exp[i]) begin failures++; $display("FAIL divzero[%0d] got=%h exp=%h", i, d, exp[i]); end
         checks++; if (lat != ZERO_LAT) begin failures++; $display("FAIL divzero_lat[%0d] got=%0d exp=%0d", i, lat, ZERO_LAT); end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] d; logic [4:0] ad; logic we; int lat, bl; int events;
      funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd9; rd_addr = 5'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h exp=0", wb_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      events = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || wb_we || busy) events++;
      end
      checks++; if (events != 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", events); end
      run_op(3'b000, 32'd3, 32'd4, 5'd9, d, ad, we, lat, bl);
      checks++; if (d !== 32'd12 || ad !== 5'd9 || we !== 1'b1 || lat != 34) begin
         failures++; $display("FAIL midrst_restart data=%h addr=%0d we=%b lat=%0d exp=c,9,1,34", d, ad, we, lat);
      end
   endtask

   task automatic test_back_to_back();
      int dones, wes; logic [31:0] d; logic [4:0] ad;
      dones = 0; wes = 0; d = '0; ad = 5'h1F;
      funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (i == 5) begin start = 1'b1; rd_addr = 5'd7; rs1_val = 32'd100; end
         if (i == 6) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin dones++; d = wb_data; ad = wb_addr; end
         if (wb_we) wes++;
      end
      checks++; if (dones != 1) begin failures++; $display("FAIL b2b_dones got=%0d exp=1", dones); end
      checks++; if (wes != 0) begin failures++; $display("FAIL rd0_we got=%0d exp=0", wes); end
      checks++; if (d !== 32'd12 || ad !== 5'd0) begin failures++; $display("FAIL rd0_result data=%h addr=%0d exp=c,0", d, ad); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mul_high();
      test_div();
      test_div_zero();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
